// File: rtl/parity_frame_tx_pkg.sv
// Shared definitions for the parity frame transmitter and its checker.
// Holds the state codes, the parity mode constants and the counter width helper.
package parity_frame_tx_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DATA   = 2'd1;
   localparam logic [1:0] ST_PARITY = 2'd2;

   localparam bit PARITY_EVEN = 1'b0;
   localparam bit PARITY_ODD  = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE   = ST_IDLE,
      S_DATA   = ST_DATA,
      S_PARITY = ST_PARITY
   } state_t;

   // A one-bit payload still needs a one-bit counter.
   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in, serial-out shift register; shifts right and presents the LSB.
// A parallel load takes priority over a shift.
module piso_shift_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         shift,
   input  logic [W-1:0] din,
   output logic         lsb
);

   logic [W-1:0] q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         q <= '0;
      end else if (load) begin
         q <= din;
      end else if (shift) begin
         q <= q >> 1;
      end
   end

   assign lsb = q[0];

endmodule

// File: rtl/parity_frame_tx.sv
// Serialises a parallel word LSB-first and appends one parity bit.
// Handshake: a word moves when in_valid and in_ready are both high at a rising edge.
module parity_frame_tx
   import parity_frame_tx_pkg::state_t, parity_frame_tx_pkg::S_IDLE,
          parity_frame_tx_pkg::S_DATA, parity_frame_tx_pkg::S_PARITY,
          parity_frame_tx_pkg::PARITY_EVEN, parity_frame_tx_pkg::cnt_width;
#(
   parameter int DATA_W     = 8,
   parameter bit PARITY_ODD = PARITY_EVEN
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] data_in,
   output logic              in_ready,
   output logic              tx_bit,
   output logic              tx_valid,
   output logic              tx_last,
   output logic [1:0]        dbg_state
);

   localparam int              CNT_W    = cnt_width(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic             par_q;
   logic             load, shift;
   logic             sh_lsb;

   piso_shift_reg #(.W(DATA_W)) u_shreg (
      .clk   (clk),
      .reset (reset),
      .load  (load),
      .shift (shift),
      .din   (data_in),
      .lsb   (sh_lsb)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         par_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (load) begin
            cnt_q <= '0;
            par_q <= (^data_in) ^ PARITY_ODD;
         end else if (shift) begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   // Outputs decode from state_q only; load/shift are internal controls.
   always_comb begin
      state_d  = state_q;
      load     = 1'b0;
      shift    = 1'b0;
      in_ready = 1'b0;
      tx_bit   = 1'b0;
      tx_valid = 1'b0;
      tx_last  = 1'b0;
      case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               load    = 1'b1;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            tx_bit   = sh_lsb;
            tx_valid = 1'b1;
            shift    = 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = S_PARITY;
            end
         end
         S_PARITY: begin
            tx_bit   = par_q;
            tx_valid = 1'b1;
            tx_last  = 1'b1;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign dbg_state = state_q;

endmodule

// File: tb/tb_parity_frame_tx.sv
// Bench for parity_frame_tx: even, odd and one-bit instances against a frame-queue model,
// plus a table of known frames and hand-written reset and back-to-back sequences.
module tb_parity_frame_tx;
   import parity_frame_tx_pkg::*;

   localparam int W = 8;

   typedef struct packed {
      logic rdy;
      logic vld;
      logic last;
      logic bt;
   } obs_t;

   typedef struct {
      logic [7:0] data;
      logic       par_e;
      logic       par_o;
   } vec_t;

   localparam obs_t IDLE_OBS = 4'b1000;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         in_valid = 1'b0;
   logic [W-1:0] data_in = '0;
   logic         in_valid1 = 1'b0;
   logic [0:0]   data1 = '0;

   logic       in_ready_e, tx_bit_e, tx_valid_e, tx_last_e;
   logic       in_ready_o, tx_bit_o, tx_valid_o, tx_last_o;
   logic       in_ready_1, tx_bit_1, tx_valid_1, tx_last_1;
   logic [1:0] dbg_state_e, dbg_state_o, dbg_state_1;

   int   total = 0;
   int   bad = 0;
   bit   chk_en = 1'b0;
   obs_t q8[$];
   obs_t q1[$];
   obs_t cur8 = IDLE_OBS;
   obs_t cur1 = IDLE_OBS;
   logic acc_e = 1'b0;
   logic acc_o = 1'b0;
   vec_t tbl[7];

   parity_frame_tx #(.DATA_W(W), .PARITY_ODD(PARITY_EVEN)) dut_even (
      .clk(clk), .reset(reset), .in_valid(in_valid), .data_in(data_in),
      .in_ready(in_ready_e), .tx_bit(tx_bit_e), .tx_valid(tx_valid_e),
      .tx_last(tx_last_e), .dbg_state(dbg_state_e)
   );

   parity_frame_tx #(.DATA_W(W), .PARITY_ODD(PARITY_ODD)) dut_odd (
      .clk(clk), .reset(reset), .in_valid(in_valid), .data_in(data_in),
      .in_ready(in_ready_o), .tx_bit(tx_bit_o), .tx_valid(tx_valid_o),
      .tx_last(tx_last_o), .dbg_state(dbg_state_o)
   );

   parity_frame_tx #(.DATA_W(1), .PARITY_ODD(PARITY_EVEN)) dut_w1 (
      .clk(clk), .reset(reset), .in_valid(in_valid1), .data_in(data1),
      .in_ready(in_ready_1), .tx_bit(tx_bit_1), .tx_valid(tx_valid_1),
      .tx_last(tx_last_1), .dbg_state(dbg_state_1)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: an accepted word becomes a queue of per-cycle observations.
   always @(posedge clk) begin
      if (!reset) begin
         q8.delete();
         q1.delete();
         cur8 = IDLE_OBS;
         cur1 = IDLE_OBS;
      end else begin
         if (cur8.rdy && in_valid) begin
            for (int i = 0; i < W; i++) q8.push_back(obs_t'({3'b010, data_in[i]}));
            q8.push_back(obs_t'({3'b011, 1'($countones(data_in) % 2)}));
         end
         if (cur1.rdy && in_valid1) begin
            q1.push_back(obs_t'({3'b010, data1[0]}));
            q1.push_back(obs_t'({3'b011, data1[0]}));
         end
         cur8 = (q8.size() > 0) ? q8.pop_front() : IDLE_OBS;
         cur1 = (q1.size() > 0) ? q1.pop_front() : IDLE_OBS;
      end
   end

   // scoreboard, sampled mid-cycle
   always @(negedge clk) begin
      obs_t eo;
      logic [1:0] exp_st;
      if (chk_en) begin
         eo = cur8;
         if (eo.last) eo.bt = ~eo.bt;
         exp_st = cur8.rdy ? ST_IDLE : (cur8.last ? ST_PARITY : ST_DATA);
         check("even_out", 16'({in_ready_e, tx_valid_e, tx_last_e, tx_bit_e}), 16'(cur8));
         check("odd_out",  16'({in_ready_o, tx_valid_o, tx_last_o, tx_bit_o}), 16'(eo));
         check("w1_out",   16'({in_ready_1, tx_valid_1, tx_last_1, tx_bit_1}), 16'(cur1));
         check("even_state", 16'(dbg_state_e), 16'(exp_st));
         // chained checker: running parity over a whole frame
         if (in_ready_e) acc_e = 1'b0;
         else if (tx_valid_e) begin
            acc_e = acc_e ^ tx_bit_e;
            if (tx_last_e) check("chk_even", 16'(acc_e), 16'd0);
         end
         if (in_ready_o) acc_o = 1'b0;
         else if (tx_valid_o) begin
            acc_o = acc_o ^ tx_bit_o;
            if (tx_last_o) check("chk_odd", 16'(acc_o), 16'd1);
         end
      end
   end

   // one-bit instance gets free-running random traffic
   initial begin
      forever begin
         @(posedge clk);
         #1;
         in_valid1 = 1'($urandom_range(0, 1));
         data1     = 1'($urandom_range(0, 1));
      end
   end

   // driver: one table frame, accepted from IDLE, then observed for ten cycles
   task automatic send_tbl(input vec_t v);
      logic [7:0] bits;
      logic [9:0] lastv, rdyv;
      logic       pe, po;
      bits = '0; lastv = '0; rdyv = '0; pe = 1'b0; po = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      data_in  = v.data;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      data_in  = 8'($urandom);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i < 8) bits[i] = tx_bit_e;
         if (i == 8) begin
            pe = tx_bit_e;
            po = tx_bit_o;
         end
         lastv[i] = tx_last_e;
         rdyv[i]  = in_ready_e;
      end
      check("tbl_bits", 16'(bits), 16'(v.data));
      check("tbl_par_even", 16'(pe), 16'(v.par_e));
      check("tbl_par_odd", 16'(po), 16'(v.par_o));
      check("tbl_last", 16'(lastv), 16'h0100);
      check("tbl_ready", 16'(rdyv), 16'h0200);
   endtask

   initial begin
      tbl[0] = '{data: 8'hA5, par_e: 1'b0, par_o: 1'b1};
      tbl[1] = '{data: 8'h07, par_e: 1'b1, par_o: 1'b0};
      tbl[2] = '{data: 8'h00, par_e: 1'b0, par_o: 1'b1};
      tbl[3] = '{data: 8'h3C, par_e: 1'b0, par_o: 1'b1};
      tbl[4] = '{data: 8'hFF, par_e: 1'b0, par_o: 1'b1};
      tbl[5] = '{data: 8'h80, par_e: 1'b1, par_o: 1'b0};
      tbl[6] = '{data: 8'h6D, par_e: 1'b1, par_o: 1'b0};

      // reset held for two edges with in_valid high, which must be ignored
      reset    = 1'b0;
      in_valid = 1'b1;
      data_in  = 8'hFF;
      repeat (2) @(posedge clk);
      #1;
      chk_en   = 1'b1;
      reset    = 1'b1;
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_idle", 16'({in_ready_e, tx_valid_e, tx_last_e, tx_bit_e}), 16'h0008);
      end

      for (int i = 0; i < 7; i++) send_tbl(tbl[i]);

      // back-to-back with data changed mid-frame
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      data_in  = 8'h3C;
      repeat (4) @(posedge clk);
      #1;
      data_in = 8'hFF;
      repeat (7) @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (12) @(posedge clk);

      // reset during the fourth data cycle aborts the frame
      #1;
      in_valid = 1'b1;
      data_in  = 8'hA5;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      check("rst_abort", 16'({in_ready_e, tx_valid_e, tx_last_e}), 16'h0004);
      send_tbl(tbl[1]);

      // random traffic with occasional resets
      repeat (400) begin
         @(posedge clk);
         #1;
         in_valid = ($urandom_range(0, 3) != 0);
         data_in  = 8'($urandom);
         reset    = ($urandom_range(0, 79) != 0);
      end
      #0;
      reset    = 1'b1;
      in_valid = 1'b0;
      repeat (12) @(posedge clk);
      @(negedge clk);
      chk_en = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
